// File: rtl/uart_tx_fifo_if.sv
// Write handshake and status bundle for the buffered UART transmitter.
// The design side uses the slave modport, the producer side the master modport.
interface uart_tx_fifo_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
);
    logic                        valid_i;
    logic [DATA_BITS-1:0]        data_i;
    logic                        ready_o;
    logic                        uart_tx_o;
    logic                        busy_o;
    logic [$clog2(FIFO_DEPTH):0] level_o;

    modport slave (
        input  valid_i, data_i,
        output ready_o, uart_tx_o, busy_o, level_o
    );

    modport master (
        output valid_i, data_i,
        input  ready_o, uart_tx_o, busy_o, level_o
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: synchronous TX FIFO feeding a framer with
// configurable data bits, parity and stop bits at a fixed FREQ/BAUD divider.
module uart_tx_fifo #(
    parameter int FREQ       = 27000000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    uart_tx_fifo_if.slave bus
);
    localparam int DIV      = FREQ / BAUD;
    localparam int CW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LW       = AW + 1;
    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;

    if (DIV < 2) begin : g_bad_div
        $error("uart_tx_fifo: FREQ/BAUD must be at least 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_fifo: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [LW-1:0]        r_level;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_empty;
    logic                 w_full;
    logic [DATA_BITS-1:0] w_rd_data;
    logic                 w_load_parity;

    state_t               r_state;
    state_t               w_state_next;
    logic [CW-1:0]        r_baud_cnt;
    logic [CW-1:0]        w_baud_next;
    logic [3:0]           r_bit_cnt;
    logic [3:0]           w_bit_next;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift_next;
    logic                 r_parity;
    logic                 w_parity_next;
    logic                 w_bit_end;
    logic                 w_tx_bit;
    logic                 r_tx;

    assign w_empty   = (r_level == '0);
    assign w_full    = (r_level == LW'(FIFO_DEPTH));
    assign w_push    = bus.valid_i && !w_full;
    assign w_rd_data = r_mem[r_rd_ptr];
    assign w_bit_end = (r_baud_cnt == CW'(DIV - 1));

    // Parity is fixed when the character is loaded, before shifting destroys it.
    assign w_load_parity = (^w_rd_data) ^ (PARITY == PAR_ODD);

    // NOTE: the storage array has no reset; only pointers and level define
    // which entries are valid, so clearing the data would be wasted logic.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + LW'(1);
            end else if (w_pop && !w_push) begin
                r_level <= r_level - LW'(1);
            end
        end
    end

    // NOTE: every output of this block is given a default before the case,
    // so no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_state_next  = r_state;
        w_baud_next   = w_bit_end ? '0 : r_baud_cnt + CW'(1);
        w_bit_next    = r_bit_cnt;
        w_shift_next  = r_shift;
        w_parity_next = r_parity;
        w_pop         = 1'b0;
        w_tx_bit      = 1'b1;

        case (r_state)
            S_IDLE: begin
                w_baud_next = '0;
                if (!w_empty) begin
                    w_pop         = 1'b1;
                    w_shift_next  = w_rd_data;
                    w_parity_next = w_load_parity;
                    w_state_next  = S_START;
                end
            end
            S_START: begin
                w_tx_bit = 1'b0;
                if (w_bit_end) begin
                    w_bit_next   = '0;
                    w_state_next = S_DATA;
                end
            end
            S_DATA: begin
                w_tx_bit = r_shift[0];
                if (w_bit_end) begin
                    w_shift_next = r_shift >> 1;
                    if (r_bit_cnt == 4'(DATA_BITS - 1)) begin
                        w_bit_next   = '0;
                        w_state_next = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
                    end else begin
                        w_bit_next = r_bit_cnt + 4'd1;
                    end
                end
            end
            S_PARITY: begin
                w_tx_bit = r_parity;
                if (w_bit_end) begin
                    w_bit_next   = '0;
                    w_state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    if (r_bit_cnt == 4'(STOP_BITS - 1)) begin
                        w_bit_next = '0;
                        // Chain straight into the next frame so there is no idle gap.
                        if (!w_empty) begin
                            w_pop         = 1'b1;
                            w_shift_next  = w_rd_data;
                            w_parity_next = w_load_parity;
                            w_state_next  = S_START;
                        end else begin
                            w_state_next = S_IDLE;
                        end
                    end else begin
                        w_bit_next = r_bit_cnt + 4'd1;
                    end
                end
            end
            default: begin
                w_baud_next  = '0;
                w_state_next = S_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the values computed before the edge, independent of block order.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state    <= S_IDLE;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_parity   <= 1'b0;
            r_tx       <= 1'b1;
        end else begin
            r_state    <= w_state_next;
            r_baud_cnt <= w_baud_next;
            r_bit_cnt  <= w_bit_next;
            r_shift    <= w_shift_next;
            r_parity   <= w_parity_next;
            r_tx       <= w_tx_bit;
        end
    end

    assign bus.ready_o   = !w_full;
    assign bus.uart_tx_o = r_tx;
    assign bus.busy_o    = (r_state != S_IDLE) || !w_empty;
    assign bus.level_o   = r_level;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: four configurations, a serial-line
// decoder and a scoreboard of characters expected on the line.
module tb_uart_tx_fifo;
    localparam int FREQ = 1600;
    localparam int BAUD = 100;
    localparam int DIV  = FREQ / BAUD;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   cyc = 0;

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(16)) if_a ();
    uart_tx_fifo_if #(.DATA_BITS(7), .FIFO_DEPTH(16)) if_b ();
    uart_tx_fifo_if #(.DATA_BITS(7), .FIFO_DEPTH(16)) if_c ();
    uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4))  if_d ();

    uart_tx_fifo #(.FREQ(FREQ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16))
        u_dut_a (.clk_i(clk), .rstn_i(rstn), .bus(if_a));
    uart_tx_fifo #(.FREQ(FREQ), .BAUD(BAUD), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(16))
        u_dut_b (.clk_i(clk), .rstn_i(rstn), .bus(if_b));
    uart_tx_fifo #(.FREQ(FREQ), .BAUD(BAUD), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(16))
        u_dut_c (.clk_i(clk), .rstn_i(rstn), .bus(if_c));
    uart_tx_fifo #(.FREQ(FREQ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4))
        u_dut_d (.clk_i(clk), .rstn_i(rstn), .bus(if_d));

    int         sel = 0;
    int         db = 8;
    int         par = 0;
    int         sb = 1;
    int         nbits = 10;
    logic       tb_valid = 1'b0;
    logic [8:0] tb_data = '0;

    assign if_a.valid_i = tb_valid && (sel == 0);
    assign if_b.valid_i = tb_valid && (sel == 1);
    assign if_c.valid_i = tb_valid && (sel == 2);
    assign if_d.valid_i = tb_valid && (sel == 3);
    assign if_a.data_i  = tb_data[7:0];
    assign if_b.data_i  = tb_data[6:0];
    assign if_c.data_i  = tb_data[6:0];
    assign if_d.data_i  = tb_data[7:0];

    logic       w_tx;
    logic       w_ready;
    logic       w_busy;
    logic [4:0] w_level;

    always_comb begin
        w_tx    = 1'b1;
        w_ready = 1'b0;
        w_busy  = 1'b0;
        w_level = '0;
        case (sel)
            0: begin
                w_tx = if_a.uart_tx_o; w_ready = if_a.ready_o; w_busy = if_a.busy_o; w_level = if_a.level_o;
            end
            1: begin
                w_tx = if_b.uart_tx_o; w_ready = if_b.ready_o; w_busy = if_b.busy_o; w_level = if_b.level_o;
            end
            2: begin
                w_tx = if_c.uart_tx_o; w_ready = if_c.ready_o; w_busy = if_c.busy_o; w_level = if_c.level_o;
            end
            default: begin
                w_tx = if_d.uart_tx_o; w_ready = if_d.ready_o; w_busy = if_d.busy_o; w_level = 5'(if_d.level_o);
            end
        endcase
    end

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Scoreboard of characters expected on the line, and frame start cycles.
    int   exp_q[$];
    int   start_q[$];
    logic m_act = 1'b0;
    int   m_cnt = 0;
    int   m_frames = 0;
    logic [15:0] m_bits = '0;
    logic m_last_par = 1'b0;

    task automatic frame_done();
        logic [31:0] e;
        logic [31:0] got;
        logic        ep;
        int          pos;
        check("stop_tail", 32'(w_tx), 1);
        check("frame_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
            e   = exp_q.pop_front();
            got = '0;
            for (int i = 0; i < db; i++) got[i] = m_bits[1 + i];
            check("start_bit", 32'(m_bits[0]), 0);
            check("data", got, e);
            pos = 1 + db;
            if (par != 0) begin
                ep = ^e;
                if (par == 1) ep = ~ep;
                m_last_par = m_bits[pos];
                check("parity_bit", 32'(m_bits[pos]), 32'(ep));
                pos++;
            end
            for (int i = 0; i < sb; i++) check("stop_bit", 32'(m_bits[pos + i]), 1);
        end
        m_frames++;
    endtask

    // Line decoder: a frame begins at the first low sample; each bit is
    // sampled mid-period, and the final sample checks the stop bit tail.
    initial begin
        forever begin
            @(negedge clk);
            if (!rstn) begin
                m_act = 1'b0;
            end else begin
                if (!m_act && w_tx == 1'b0) begin
                    m_act  = 1'b1;
                    m_cnt  = 0;
                    m_bits = '0;
                    start_q.push_back(cyc);
                end
                if (m_act) begin
                    if (m_cnt % DIV == DIV / 2) m_bits[m_cnt / DIV] = w_tx;
                    if (m_cnt == nbits * DIV - 1) begin
                        frame_done();
                        m_act = 1'b0;
                    end
                    m_cnt++;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    int t_push = 0;

    task automatic set_cfg(input int s, input int d, input int p, input int st);
        sel   = s;
        db    = d;
        par   = p;
        sb    = st;
        nbits = 1 + d + ((p != 0) ? 1 : 0) + st;
    endtask

    task automatic push_byte(input int d);
        int t;
        t = 0;
        @(negedge clk);
        while (!w_ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("push_ready", 32'(w_ready), 1);
        tb_valid = 1'b1;
        tb_data  = 9'(d);
        t_push   = cyc;
        exp_q.push_back(d & ((1 << db) - 1));
        @(negedge clk);
        tb_valid = 1'b0;
    endtask

    task automatic drain(input int max);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || m_act || w_busy) && t < max) begin
            @(negedge clk);
            t++;
        end
        check("drain_in_time", 32'(t < max), 1);
        repeat (4) @(negedge clk);
    endtask

    // One frame from idle: latency to the start bit and total busy time.
    task automatic frame_check(input int d, input int exp_busy, input string tag);
        int busy_n;
        busy_n = 0;
        push_byte(d);
        for (int k = 0; k < 1000; k++) begin
            if (k == 0) check({tag, "_tx_edge0"}, 32'(w_tx), 1);
            if (k == 1) check({tag, "_tx_edge1"}, 32'(w_tx), 1);
            if (k == 2) check({tag, "_tx_edge2"}, 32'(w_tx), 0);
            if (!w_busy) break;
            busy_n++;
            @(negedge clk);
        end
        check({tag, "_busy_cycles"}, busy_n, exp_busy);
        drain(600);
    endtask

    initial begin
        int t0;
        int t;
        int nd;
        int n_acc;
        int lows;
        int frames0;

        // Reset state
        set_cfg(0, 8, 0, 1);
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(w_tx), 1);
        check("rst_ready", 32'(w_ready), 1);
        check("rst_busy", 32'(w_busy), 0);
        check("rst_level", 32'(w_level), 0);
        #2 rstn = 1'b1;
        repeat (2) @(negedge clk);

        // 8N1 single frame: 10 bits of 16 cycles, plus the push-to-pop cycle
        frame_check(8'h55, 161, "8n1");

        // 7E2 and 7O2: 11 bits of 16 cycles
        set_cfg(1, 7, 2, 2);
        frame_check(8'h53, 177, "7e2");
        check("even_parity_bit", 32'(m_last_par), 0);
        set_cfg(2, 7, 1, 2);
        frame_check(8'h53, 177, "7o2");
        check("odd_parity_bit", 32'(m_last_par), 1);

        // Depth-4 FIFO with valid held high
        set_cfg(3, 8, 0, 1);
        start_q.delete();
        nd    = 0;
        n_acc = 0;
        @(negedge clk);
        t0 = cyc;
        while (w_ready && n_acc < 20) begin
            tb_valid = 1'b1;
            tb_data  = 9'(nd);
            exp_q.push_back(nd);
            nd++;
            n_acc++;
            @(negedge clk);
        end
        check("accepted_before_full", n_acc, 5);
        check("level_peak", 32'(w_level), 4);
        tb_data = 9'(nd);
        t = 0;
        while (!w_ready && t < 400) begin
            @(negedge clk);
            t++;
        end
        check("ready_rerise_cycle", cyc - t0, 162);
        exp_q.push_back(nd);
        @(negedge clk);
        tb_valid = 1'b0;
        drain(2000);
        check("fifo_frame_count", start_q.size(), 6);
        for (int i = 1; i < start_q.size(); i++) check("frame_gap", start_q[i] - start_q[i - 1], 160);

        // Simultaneous push and pop with two characters queued
        set_cfg(0, 8, 0, 1);
        frames0 = m_frames;
        push_byte(8'h11);
        t0 = t_push;
        push_byte(8'h22);
        push_byte(8'h33);
        while (cyc < t0 + 161) @(negedge clk);
        check("level_before_pushpop", 32'(w_level), 2);
        tb_valid = 1'b1;
        tb_data  = 9'h44;
        exp_q.push_back(8'h44);
        @(negedge clk);
        tb_valid = 1'b0;
        check("level_after_pushpop", 32'(w_level), 2);
        drain(1200);
        check("pushpop_frames", m_frames - frames0, 4);

        // Reset during data bit 3 of 0xA5 with three characters queued
        push_byte(8'hA5);
        t0 = t_push;
        push_byte(8'hB1);
        push_byte(8'hB2);
        push_byte(8'hB3);
        while (cyc < t0 + 71) @(negedge clk);
        check("pre_reset_bit3", 32'(w_tx), 0);
        check("pre_reset_level", 32'(w_level), 3);
        #2 rstn = 1'b0;
        #1;
        check("async_rst_tx", 32'(w_tx), 1);
        check("async_rst_level", 32'(w_level), 0);
        check("async_rst_ready", 32'(w_ready), 1);
        check("async_rst_busy", 32'(w_busy), 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        #2 rstn = 1'b1;
        lows = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (w_tx == 1'b0 || w_busy) lows++;
        end
        check("line_idle_after_reset", lows, 0);
        frames0 = m_frames;
        frame_check(8'h3C, 161, "post_rst");
        check("post_rst_frames", m_frames - frames0, 1);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
